mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Arbitrates the instruction-fetch port and the load/store port onto one byte-wide, single-port RAM.
- Serialises 8/16/32-bit accesses as byte sequences and assembles read words.
- Produces stallreq_if / stallreq_mem for the pipeline stall controller.
- Sits between IF/MEM stages and the RAM.

Parameters:
- ADDR_W, 32, address width of request ports and RAM address.
- ISSUE_BYTES_IF, 4, bytes per instruction fetch; fixed at 4 in this design.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  ADDR_W  fetch byte address.
- if_data  out  32  fetched instruction; valid while if_done=1.
- if_done  out  1  one-cycle completion pulse for fetch.
- stallreq_if  out  1  = if_req & ~if_done (combinational).
- mem_req  in  1  load/store request; held until mem_done.
- mem_we  in  1  1=store, 0=load.
- mem_len  in  2  00=byte, 01=half, 11=word; 10 is treated as word.
- mem_addr  in  ADDR_W  data byte address.
- mem_wdata  in  32  store data; low bytes first.
- mem_rdata  out  32  load data, zero-extended; valid while mem_done=1.
- mem_done  out  1  one-cycle completion pulse for load/store.
- stallreq_mem  out  1  = mem_req & ~mem_done (combinational).
- ram_a  out  ADDR_W  RAM byte address.
- ram_dout  out  8  RAM write data.
- ram_wr  out  1  RAM write enable.
- ram_din  in  8  RAM read data; 1-cycle latency after ram_a.

Behaviour:
- Reset (rst=0 at edge): state IDLE, ram_wr=0, ram_a=0, ram_dout=0, if_done=0, mem_done=0, if_data=0, mem_rdata=0, byte counter=0.
- States: IDLE, RD, WR, FIN.
- IDLE arbitration: mem_req has priority. If mem_req=1, latch addr/len/wdata/we and select the MEM client. Else if if_req=1, latch if_addr, N=4, select the IF client. Else stay in IDLE. Next state is WR if store, else RD.
- N (bytes) = 1, 2 or 4 from len.
- Addressing: ram_a = base+k, mod 2^ADDR_W; wrap-around is legal. No alignment requirement.
- RD: cycle k=0..N-1 drives ram_a=base+k. ram_din sampled in cycle k+1 goes into byte k (little-endian). One extra cycle (k=N) captures the last byte, then go to FIN.
- WR: cycle k=0..N-1 drives ram_a=base+k, ram_dout=wdata[8k+7:8k], ram_wr=1, then go to FIN. ram_wr=0 in every other state.
- FIN: one cycle.
  - Pulse the selected client's done (registered output high for exactly this cycle).
  - Present data: mem_rdata upper unused bytes=0; stores return mem_rdata=0.
  - Return to IDLE.
- Latency from the IDLE accept cycle to the done cycle: read N+2 cycles, write N+1 cycles. IF fetch = 6 cycles.
- Requesters drop or change their request in the cycle after done. A request still high in the IDLE cycle after FIN is a new transaction.
- Request inputs are ignored outside IDLE, except the optional preempt.
- Simultaneous if_req & mem_req in IDLE: MEM served first, IF served next.
- Reset mid-transaction: abort immediately to IDLE, no done pulse, ram_wr=0 in the following cycle.

Optional Feature:
- Macro: MEM_CTRL_IF_PREEMPT_EN.
- Defined: in RD serving IF, if mem_req=1 in any cycle, abandon the fetch. No if_done; partial data discarded. Next cycle returns to IDLE, where MEM is accepted. The fetch restarts from byte 0 after MEM completes (if_req still held).
- Undefined: a fetch always runs to completion; mem_req waits.

Test Plan:
- Reset, then if_req=1, if_addr=0x100, RAM[0x100..0x103]=13,00,00,00 -> if_done one cycle at accept+6, if_data=0x00000013, stallreq_if high until that cycle.
- Word store mem_addr=0x200, mem_wdata=0xDEADBEEF -> ram_wr for 4 cycles writing EF,BE,AD,DE to 0x200..0x203, mem_done at accept+5.
- Byte load mem_len=00 at 0x203 after the store -> mem_rdata=0x000000DE at accept+3.
- if_req and mem_req rise together (load word 0x200) -> MEM done first (0xDEADBEEF), IF accepted in the next IDLE cycle; no ram access overlap.
- Half-word load at address 0xFFFFFFFF -> bytes fetched from 0xFFFFFFFF then 0x00000000.
- rst=0 mid-store after 2 bytes -> ram_wr=0 next cycle, no mem_done. With MEM_CTRL_IF_PREEMPT_EN: mem_req during fetch byte 2 -> fetch abandoned, MEM completes, fetch restarts and completes.

Source files
------------

// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_if
// Purpose  : Bundles the fetch port, load/store port and byte-wide RAM port
//            of mem_ctrl.
//   slave  : the controller side (mem_ctrl)
//   master : the environment side (pipeline stages plus the RAM)
// Signals  : if_*  fetch request/response and stallreq_if
//            mem_* load/store request/response and stallreq_mem
//            ram_* byte-wide single-port RAM (ram_din has 1-cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_data;
  logic              if_done;
  logic              stallreq_if;

  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic              stallreq_mem;

  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic [7:0]        ram_din;

  modport slave (
    input  if_req, if_addr,
    output if_data, if_done, stallreq_if,
    input  mem_req, mem_we, mem_len, mem_addr, mem_wdata,
    output mem_rdata, mem_done, stallreq_mem,
    output ram_a, ram_dout, ram_wr,
    input  ram_din
  );

  modport master (
    output if_req, if_addr,
    input  if_data, if_done, stallreq_if,
    output mem_req, mem_we, mem_len, mem_addr, mem_wdata,
    input  mem_rdata, mem_done, stallreq_mem,
    input  ram_a, ram_dout, ram_wr,
    output ram_din
  );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Arbitrates instruction fetch and load/store onto one byte-wide
//            single-port RAM. Multi-byte accesses are serialised low byte
//            first; read bytes are assembled little-endian.
// Ports    : clk  - system clock (rising edge)
//            rst  - synchronous active-low reset
//            bus  - mem_ctrl_if.slave (fetch, load/store and RAM signals)
// Options  : MEM_CTRL_IF_PREEMPT_EN - a pending load/store abandons an
//            in-progress fetch; the fetch restarts from byte 0 afterwards.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int ISSUE_BYTES_IF = 4
) (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [2:0] IF_BYTES = 3'(ISSUE_BYTES_IF);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [2:0]        k_q, k_d;
  logic              sel_mem_q, sel_mem_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic              preempt;
  logic [2:0]        k_inc;
  logic [1:0]        cap_idx;
  logic [2:0]        mem_nbytes;

  assign k_inc   = k_q + 3'd1;
  // Byte captured in RD cycle k was addressed in cycle k-1.
  assign cap_idx = 2'(k_q - 3'd1);

  always_comb begin
    case (bus.mem_len)
      2'b00:   mem_nbytes = 3'd1;
      2'b01:   mem_nbytes = 3'd2;
      default: mem_nbytes = 3'd4;
    endcase
  end

`ifdef MEM_CTRL_IF_PREEMPT_EN
  assign preempt = ~sel_mem_q & bus.mem_req;
`else
  assign preempt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      nbytes_q    <= '0;
      k_q         <= '0;
      sel_mem_q   <= 1'b0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      nbytes_q    <= nbytes_d;
      k_q         <= k_d;
      sel_mem_q   <= sel_mem_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // RAM-side outputs and done pulses are registered: the values computed
  // here appear in the cycle after the decision.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    nbytes_d    = nbytes_q;
    k_d         = k_q;
    sel_mem_d   = sel_mem_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          sel_mem_d  = 1'b1;
          base_d     = bus.mem_addr;
          nbytes_d   = mem_nbytes;
          wdata_d    = bus.mem_wdata;
          ram_dout_d = bus.mem_wdata[7:0];
          ram_wr_d   = bus.mem_we;
          state_d    = bus.mem_we ? WR : RD;
        end else if (bus.if_req) begin
          sel_mem_d  = 1'b0;
          base_d     = bus.if_addr;
          nbytes_d   = IF_BYTES;
          state_d    = RD;
        end
        if (bus.mem_req || bus.if_req) begin
          k_d     = 3'd0;
          rbuf_d  = '0;
          ram_a_d = base_d;
        end
      end

      RD: begin
        if (k_q != 3'd0) rbuf_d[{cap_idx, 3'b000} +: 8] = bus.ram_din;
        if (preempt) begin
          state_d = IDLE;
        end else if (k_q == nbytes_q) begin
          state_d = FIN;
          if (sel_mem_q) begin
            mem_done_d  = 1'b1;
            mem_rdata_d = rbuf_d;
          end else begin
            if_done_d = 1'b1;
            if_data_d = rbuf_d;
          end
        end else begin
          k_d = k_inc;
          if (k_inc < nbytes_q) ram_a_d = base_q + ADDR_W'(k_inc);
        end
      end

      WR: begin
        if (k_inc == nbytes_q) begin
          state_d = FIN;
          if (sel_mem_q) begin
            mem_done_d  = 1'b1;
            mem_rdata_d = '0;
          end else begin
            if_done_d = 1'b1;
          end
        end else begin
          k_d        = k_inc;
          ram_a_d    = base_q + ADDR_W'(k_inc);
          // Store data is shifted so the next byte is always at [15:8].
          ram_dout_d = wdata_q[15:8];
          wdata_d    = {8'h00, wdata_q[31:8]};
          ram_wr_d   = 1'b1;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ram_a        = ram_a_q;
  assign bus.ram_dout     = ram_dout_q;
  assign bus.ram_wr       = ram_wr_q;
  assign bus.if_done      = if_done_q;
  assign bus.mem_done     = mem_done_q;
  assign bus.if_data      = if_data_q;
  assign bus.mem_rdata    = mem_rdata_q;
  assign bus.stallreq_if  = bus.if_req & ~if_done_q;
  assign bus.stallreq_mem = bus.mem_req & ~mem_done_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Self-checking bench for mem_ctrl. A behavioural byte RAM sits
//            on the RAM port; expected completions (client, data, cycle) are
//            queued when a request is issued and compared on each done pulse.
// Options  : MEM_CTRL_IF_PREEMPT_EN selects the expected fetch/load ordering
//            of the preemption sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32), .ISSUE_BYTES_IF(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Byte RAM with one cycle read latency; address aliased to 10 bits.
  logic [7:0] ram [0:1023];
  always @(posedge clk) begin
    if (bus.ram_wr) ram[bus.ram_a[9:0]] <= bus.ram_dout;
    bus.ram_din <= ram[bus.ram_a[9:0]];
  end

  typedef struct {
    bit          is_mem;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && (bus.if_done || bus.mem_done)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got if_done=%0b mem_done=%0b expected none",
                 bus.if_done, bus.mem_done);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_client", {31'd0, bus.mem_done}, {31'd0, e.is_mem});
        chk("done_data", bus.mem_done ? bus.mem_rdata : bus.if_data, e.data);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_done(input bit is_mem);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (is_mem && bus.mem_done) begin
        seen = 1'b1;
        chk("stallreq_mem_at_done", {31'd0, bus.stallreq_mem}, 32'd0);
        bus.mem_req = 1'b0;
      end else if (!is_mem && bus.if_done) begin
        seen = 1'b1;
        chk("stallreq_if_at_done", {31'd0, bus.stallreq_if}, 32'd0);
        bus.if_req = 1'b0;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done for is_mem=%0b expected done within 60 cycles", is_mem);
      if (is_mem) bus.mem_req = 1'b0;
      else        bus.if_req  = 1'b0;
    end
  endtask

  task automatic drive_mem(input bit we, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.mem_we    = we;
    bus.mem_len   = len;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_req   = 1'b1;
  endtask

  initial begin
    int t0;
    int nwr;

    //             mem we  len    addr          wdata         expected      lat
    vecs[0]  = '{1'b1, 1'b1, 2'b11, 32'h0000_0100, 32'h0000_0013, 32'h0000_0000, 5};
    vecs[1]  = '{1'b0, 1'b0, 2'b11, 32'h0000_0100, 32'h0,         32'h0000_0013, 6};
    vecs[2]  = '{1'b1, 1'b1, 2'b11, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0000_0000, 5};
    vecs[3]  = '{1'b1, 1'b0, 2'b00, 32'h0000_0203, 32'h0,         32'h0000_00DE, 3};
    vecs[4]  = '{1'b1, 1'b0, 2'b01, 32'h0000_0201, 32'h0,         32'h0000_ADBE, 4};
    vecs[5]  = '{1'b1, 1'b0, 2'b11, 32'h0000_0200, 32'h0,         32'hDEAD_BEEF, 6};
    vecs[6]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0200, 32'h0,         32'hDEAD_BEEF, 6};
    vecs[7]  = '{1'b1, 1'b1, 2'b01, 32'h0000_0210, 32'hCAFE_1234, 32'h0000_0000, 3};
    vecs[8]  = '{1'b1, 1'b0, 2'b01, 32'h0000_0210, 32'h0,         32'h0000_1234, 4};
    vecs[9]  = '{1'b1, 1'b1, 2'b00, 32'h0000_0220, 32'hFFFF_FFA7, 32'h0000_0000, 2};
    vecs[10] = '{1'b1, 1'b0, 2'b00, 32'h0000_0220, 32'h0,         32'h0000_00A7, 3};
    vecs[11] = '{1'b1, 1'b1, 2'b01, 32'hFFFF_FFFF, 32'h0000_A55A, 32'h0000_0000, 3};
    vecs[12] = '{1'b1, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0,         32'h0000_A55A, 4};
    vecs[13] = '{1'b1, 1'b1, 2'b11, 32'h0000_0300, 32'hFFFF_FFFF, 32'h0000_0000, 5};
    vecs[14] = '{1'b0, 1'b0, 2'b11, 32'h0000_0200, 32'h0,         32'hDEAD_BEEF, 6};

    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_len   = 2'b00;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_if_done",   {31'd0, bus.if_done},  32'd0);
    chk("rst_mem_done",  {31'd0, bus.mem_done}, 32'd0);
    chk("rst_ram_wr",    {31'd0, bus.ram_wr},   32'd0);
    chk("rst_ram_a",     bus.ram_a,             32'd0);
    chk("rst_ram_dout",  {24'd0, bus.ram_dout}, 32'd0);
    chk("rst_if_data",   bus.if_data,           32'd0);
    chk("rst_mem_rdata", bus.mem_rdata,         32'd0);
    rst = 1'b1;

    // Table-driven single transactions
    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      sb.push_back('{vecs[v].is_mem, vecs[v].exp, cyc + vecs[v].lat});
      if (vecs[v].is_mem) begin
        drive_mem(vecs[v].we, vecs[v].len, vecs[v].addr, vecs[v].wdata);
      end else begin
        bus.if_addr = vecs[v].addr;
        bus.if_req  = 1'b1;
      end
      #1;
      if (vecs[v].is_mem) chk("stallreq_mem_issue", {31'd0, bus.stallreq_mem}, 32'd1);
      else                chk("stallreq_if_issue",  {31'd0, bus.stallreq_if},  32'd1);
      wait_done(vecs[v].is_mem);
    end

    chk("ram_200", {24'd0, ram[10'h200]}, 32'h0000_00EF);
    chk("ram_203", {24'd0, ram[10'h203]}, 32'h0000_00DE);
    chk("ram_wrap_hi", {24'd0, ram[10'h3FF]}, 32'h0000_005A);
    chk("ram_wrap_lo", {24'd0, ram[10'h000]}, 32'h0000_00A5);

    // Simultaneous requests: load served first, fetch accepted after FIN
    @(negedge clk);
    t0 = cyc;
    sb.push_back('{1'b1, 32'hDEAD_BEEF, t0 + 6});
    sb.push_back('{1'b0, 32'h0000_0013, t0 + 13});
    drive_mem(1'b0, 2'b11, 32'h0000_0200, 32'h0);
    bus.if_addr = 32'h0000_0100;
    bus.if_req  = 1'b1;
    fork
      wait_done(1'b1);
      wait_done(1'b0);
    join

    // Reset after two bytes of a word store
    @(negedge clk);
    drive_mem(1'b1, 2'b11, 32'h0000_0300, 32'h1122_3344);
    nwr = 0;
    for (int i = 0; i < 20 && nwr < 2; i++) begin
      @(negedge clk);
      if (bus.ram_wr) nwr++;
    end
    chk("abort_writes_seen", nwr, 2);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ram_wr",   {31'd0, bus.ram_wr},   32'd0);
    chk("abort_mem_done", {31'd0, bus.mem_done}, 32'd0);
    bus.mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_ram_300", {24'd0, ram[10'h300]}, 32'h0000_0044);
    chk("abort_ram_301", {24'd0, ram[10'h301]}, 32'h0000_0033);
    chk("abort_ram_302", {24'd0, ram[10'h302]}, 32'h0000_00FF);

    // Load request arriving during fetch byte 2
    @(negedge clk);
    t0 = cyc;
`ifdef MEM_CTRL_IF_PREEMPT_EN
    sb.push_back('{1'b1, 32'h0000_00DE, t0 + 7});
    sb.push_back('{1'b0, 32'h0000_0013, t0 + 14});
`else
    sb.push_back('{1'b0, 32'h0000_0013, t0 + 6});
    sb.push_back('{1'b1, 32'h0000_00DE, t0 + 10});
`endif
    bus.if_addr = 32'h0000_0100;
    bus.if_req  = 1'b1;
    repeat (3) @(negedge clk);
    drive_mem(1'b0, 2'b00, 32'h0000_0203, 32'h0);
    fork
      wait_done(1'b1);
      wait_done(1'b0);
    join

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
